// File: rtl/spad_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spad_stream_ctrl
// Brief    : Fills a PE scratchpad from a valid/ready stream, then replays the
//            stored words in address order a configurable number of times.
// Revision : 1.0 - initial release
// ============================================================================
module spad_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 6,
    parameter int SIZE  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR:0]     cfg_len,
    input  logic [3:0]        cfg_reps,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic              spad_wen,
    output logic [WIDTH-1:0]  spad_wrdata,
    output logic [ADDR-1:0]   spad_addr,
    input  logic [WIDTH-1:0]  spad_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR:0]   c_len_max = (ADDR+1)'(SIZE);
    localparam logic [ADDR:0]   c_len_one = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] c_ptr_one = ADDR'(1);

    state_t          r_state;
    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [3:0]      r_pass;
    logic [ADDR:0]   r_len;
    logic [3:0]      r_reps;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_cfg_ok;
    logic [ADDR:0]   w_len_m1;
    logic            w_wr_hs;
    logic            w_rd_hs;
    logic            w_wr_last;
    logic            w_rd_last;
    logic [3:0]      w_pass_nxt;

    assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= c_len_max);
    assign w_len_m1   = r_len - c_len_one;
    assign w_wr_hs    = in_valid && r_in_ready;
    assign w_rd_hs    = r_out_valid && out_ready;
    assign w_wr_last  = ({1'b0, r_wr_ptr} == w_len_m1);
    assign w_rd_last  = ({1'b0, r_rd_ptr} == w_len_m1);
    assign w_pass_nxt = r_pass + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pass      <= '0;
            r_len       <= '0;
            r_reps      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_len      <= cfg_len;
                            r_reps     <= cfg_reps;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_pass     <= '0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_wr_hs) begin
                        // Full-depth jobs rely on the natural ADDR-bit wrap to 0.
                        r_wr_ptr <= r_wr_ptr + c_ptr_one;
                        if (w_wr_last) begin
                            r_in_ready <= 1'b0;
                            if (r_reps != 4'd0) begin
                                r_out_valid <= 1'b1;
                                r_state     <= ST_DRAIN;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_hs) begin
                        if (w_rd_last) begin
                            r_rd_ptr <= '0;
                            r_pass   <= w_pass_nxt;
                            if (w_pass_nxt == r_reps) begin
                                r_out_valid <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= ST_DONE;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ptr_one;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Scratchpad port is steered by state; rdata passes straight through.
    assign spad_wen    = (r_state == ST_FILL) && in_valid;
    assign spad_wrdata = in_data;
    assign spad_addr   = (r_state == ST_FILL)  ? r_wr_ptr :
                         (r_state == ST_DRAIN) ? r_rd_ptr : '0;
    assign out_data    = spad_rdata;
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spad_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spad_stream_ctrl
// Brief    : Scoreboard bench for spad_stream_ctrl with a behavioural scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spad_stream_ctrl;

    localparam int WIDTH = 8;
    localparam int ADDR  = 6;
    localparam int SIZE  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR:0]     cfg_len = '0;
    logic [3:0]        cfg_reps = '0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready = 1'b0;
    logic              spad_wen;
    logic [WIDTH-1:0]  spad_wrdata;
    logic [ADDR-1:0]   spad_addr;
    logic [WIDTH-1:0]  spad_rdata;
    logic              busy;
    logic              done;
    logic              err;

    logic [WIDTH-1:0]  mem [SIZE];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int last_out_cyc = 0;
    int last_wr_cyc = 0;

    logic [WIDTH-1:0]      exp_out[$];
    logic [ADDR+WIDTH-1:0] exp_wr[$];

    spad_stream_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .spad_wen(spad_wen), .spad_wrdata(spad_wrdata), .spad_addr(spad_addr),
        .spad_rdata(spad_rdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural scratchpad: synchronous write, combinational read.
    assign spad_rdata = mem[spad_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spad_wen) mem[spad_addr] <= spad_wrdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected value 0x%0h (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT writes or emits a word.
    always @(negedge clk) begin
        logic [ADDR+WIDTH-1:0] e;
        if (rst_n) begin
            if (spad_wen) begin
                if (exp_wr.size() == 0) flag("unexpected_write", {spad_addr, spad_wrdata});
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", spad_addr, e[ADDR+WIDTH-1:WIDTH]);
                    chk("wr_data", spad_wrdata, e[WIDTH-1:0]);
                end
                last_wr_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) flag("unexpected_out", out_data);
                else chk("out_data", out_data, exp_out.pop_front());
                last_out_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
        end
    end

    task automatic do_job(input int len, input int reps, input int base, input int step,
                          input bit toggle, input int stall_at, input int stall_n,
                          input int abort_at, input bit poke_start);
        logic [WIDTH-1:0] dat [SIZE];
        int idx, j, out_cnt, stall_left, d0, e0;
        bit hs, got_done;
        for (int i = 0; i < len; i++) begin
            dat[i] = WIDTH'(base + i * step);
            exp_wr.push_back({ADDR'(i), dat[i]});
        end
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < len; i++) exp_out.push_back(dat[i]);
        d0 = done_cnt;
        e0 = err_cnt;
        cfg_len   = (ADDR+1)'(len);
        cfg_reps  = 4'(reps);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0;
        j   = 0;
        while (idx < len && j < 4 * SIZE + 8) begin
            in_valid = toggle ? (j % 2 == 0) : 1'b1;
            in_data  = dat[idx];
            if (poke_start && j == 2) begin
                start   = 1'b1;
                cfg_len = (ADDR+1)'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (j == 0) begin
                chk("busy_in_fill", busy, 1);
                chk("in_ready_in_fill", in_ready, 1);
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            j++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("fill_words", idx, len);
        chk("fill_cycles", j, toggle ? 2 * len - 1 : len);

        out_cnt    = 0;
        stall_left = stall_n;
        got_done   = 1'b0;
        for (int k = 0; k < SIZE * 16 + 64 && !got_done; k++) begin
            out_ready = !(stall_left > 0 && out_cnt == stall_at);
            @(negedge clk);
            if (done) got_done = 1'b1;
            else begin
                if (!out_ready) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_addr", spad_addr, ADDR'(stall_at % len));
                    chk("stall_data", out_data, dat[stall_at % len]);
                    stall_left--;
                end
                if (out_valid && out_ready) out_cnt++;
                if (abort_at >= 0 && out_cnt == abort_at) begin
                    @(posedge clk); #1;
                    rst_n = 1'b0;
                    #1;
                    chk("abort_out_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_spad_wen", spad_wen, 0);
                    chk("abort_in_ready", in_ready, 0);
                    exp_out.delete();
                    exp_wr.delete();
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
                @(posedge clk); #1;
            end
        end
        chk("done_seen", got_done, 1);
        chk("out_handshakes", out_cnt, len * reps);
        chk("stall_consumed", stall_left, 0);
        @(posedge clk); #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("no_err", err_cnt - e0, 0);
        chk("exp_wr_empty", exp_wr.size(), 0);
        chk("exp_out_empty", exp_out.size(), 0);
        chk("done_latency", done_cyc - ((reps != 0) ? last_out_cyc : last_wr_cyc), 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_addr", spad_addr, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    task automatic start_bad(input int len);
        int e0;
        e0       = err_cnt;
        cfg_len  = (ADDR+1)'(len);
        cfg_reps = 4'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_busy_after", busy, 0);
        chk("err_count", err_cnt - e0, 1);
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_spad_wen", spad_wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_spad_addr", spad_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_job(4, 1, 'h11, 'h11, 1'b0, -1, 0, -1, 1'b0);
        do_job(3, 3, 'hA0, 'h10, 1'b0, -1, 0, -1, 1'b0);
        do_job(8, 1, 'h05, 'h07, 1'b1, 3, 5, -1, 1'b0);
        do_job(64, 1, 1, 3, 1'b0, -1, 0, -1, 1'b0);
        start_bad(0);
        start_bad(65);
        do_job(5, 0, 'h30, 1, 1'b0, -1, 0, -1, 1'b0);
        do_job(5, 1, 'h50, 1, 1'b0, -1, 0, 2, 1'b0);
        do_job(2, 1, 'hE1, 'h0F, 1'b0, -1, 0, -1, 1'b0);
        do_job(6, 2, 'h21, 'h13, 1'b0, -1, 0, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spad_stream_ctrl.md
Name: spad_stream_ctrl

Overview:
- Initiator/controller for a PE scratchpad, i.e. the block that drives the scratchpad's clk/wen/wrdata/addr port and consumes its combinational rdata.
- Accepts a valid/ready input stream and writes it into consecutive scratchpad addresses (FILL).
- Replays the stored words in address order as a valid/ready output stream a configurable number of times (DRAIN), e.g. for weight reuse across PE passes.
- Sits between the PE's operand feeder and its scratchpad instance.

Parameters:
- WIDTH, 8, data word width; must equal the scratchpad data width.
- ADDR, 6, scratchpad address width.
- SIZE, 64, scratchpad depth in words; SIZE <= 2^ADDR.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a job; sampled only in IDLE.
- cfg_len  input  ADDR+1  words to fill, legal range 1..SIZE; sampled with start.
- cfg_reps  input  4  drain passes, 0..15; sampled with start.
- in_valid  input  1  input word valid.
- in_data  input  WIDTH  input word.
- in_ready  output  1  controller accepts in_data.
- out_valid  output  1  out_data valid.
- out_data  output  WIDTH  replayed word.
- out_ready  input  1  downstream accepts out_data.
- spad_wen  output  1  scratchpad write enable.
- spad_wrdata  output  WIDTH  scratchpad write data.
- spad_addr  output  ADDR  scratchpad address.
- spad_rdata  input  WIDTH  scratchpad combinational read data; valid only while spad_wen=0.
- busy  output  1  high in FILL or DRAIN.
- done  output  1  one-cycle pulse when a job completes.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE; wr_ptr, rd_ptr, pass counter, len_q and reps_q all cleared.
- in_ready=0, out_valid=0, spad_wen=0, busy=0, done=0, err=0, spad_addr=0.

FSM states: IDLE, FILL, DRAIN, DONE.

IDLE:
- If start and 1 <= cfg_len <= SIZE: latch len_q=cfg_len and reps_q=cfg_reps, clear the pointers, go to FILL.
- If start with cfg_len=0 or cfg_len>SIZE: pulse err for one cycle and stay in IDLE.
- start outside IDLE is ignored (no err).

FILL:
- in_ready=1.
- spad_wen = in_valid (combinational); spad_addr=wr_ptr; spad_wrdata=in_data.
- Each handshake (in_valid & in_ready) writes the word at the rising edge and increments wr_ptr.
- On the handshake where wr_ptr = len_q-1: go to DRAIN if reps_q != 0, otherwise go to DONE.
- Accepted-word count is exactly len_q. No backpressure inside FILL.

DRAIN:
- spad_wen=0; spad_addr=rd_ptr; out_data=spad_rdata (combinational, zero added latency); out_valid=1.
- On each handshake (out_valid & out_ready), rd_ptr increments.
- When rd_ptr = len_q-1 is consumed, rd_ptr wraps to 0 and the pass counter increments.
- After reps_q passes complete, go to DONE.
- If out_ready is held low, out_data and spad_addr stay stable.

DONE:
- done=1 for exactly one cycle, then IDLE. busy=0 in DONE.

Outside FILL/DRAIN:
- in_ready=0, out_valid=0, spad_wen=0, spad_addr=0.
- out_data is don't-care when out_valid=0.

Width and ordering rules:
- Pointers are ADDR bits; pass counter is 4 bits. With len_q=SIZE=2^ADDR, the pointer naturally wraps to 0.
- Write order and read order are both ascending from 0.
- A job writes only addresses 0..len_q-1; addresses >= len_q keep stale contents and are never read.

Reset mid-job:
- Aborts immediately with all outputs at their reset values.
- Scratchpad contents are undefined from the controller's view; the next job refills them.

Test Plan:
- Basic: start, cfg_len=4, cfg_reps=1, stream 0x11,0x22,0x33,0x44 with in_valid held high -> writes at addresses 0..3 on consecutive cycles; out_data 0x11,0x22,0x33,0x44 on consecutive cycles; done pulses the cycle after the last output handshake.
- Reuse: cfg_len=3, cfg_reps=3, data A,B,C -> out sequence A,B,C,A,B,C,A,B,C; exactly 9 output handshakes, then one done pulse.
- Backpressure/bubbles: cfg_len=8 with in_valid toggling every other cycle and out_ready low for 5 cycles mid-drain -> no writes on in_valid=0 cycles; out_data and spad_addr stable while stalled; output sequence unchanged.
- Boundaries: cfg_len=64, cfg_reps=1 -> addresses 0..63 written and read, pointer wraps to 0, done pulses. cfg_len=0 and cfg_len=65 -> err pulse for one cycle, busy stays 0. cfg_reps=0 -> fill completes, no out_valid, then done.
- Reset mid-drain: assert rst_n=0 after 2 of 5 outputs -> out_valid, busy and spad_wen drop asynchronously. After release, a new job with cfg_len=2 runs correctly from address 0.
- Start while busy: pulse start during FILL with a different cfg_len -> ignored; original job length preserved; no err.
